uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority vote and FWFT FIFO; optional break detect via UART_RX_BREAK_DETECT_EN
module uart_rx_cfg #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        bit_in,
   output logic [DATA_BITS-1:0]        byte_out_data,
   output logic                        byte_out_parity_err,
   output logic                        byte_out_frame_err,
   output logic                        byte_out_valid,
   input  logic                        byte_out_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
`ifdef UART_RX_BREAK_DETECT_EN
   ,
   output logic                        break_det
`endif
);
   localparam int TICKS = CLK_FREQ_HZ / BAUD_RATE;
   localparam int MID   = (TICKS - 1) / 2;
   localparam int CW    = $clog2(TICKS + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = DATA_BITS + 2;
   localparam logic [CW-1:0] D_START   = CW'(MID + 1);
   localparam logic [CW-1:0] D_BIT     = CW'(TICKS - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic          ODD       = (PARITY == 1);

   if (TICKS < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_STAGES < 2) begin : g_bad_params
      $error("uart_rx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] sync_q, fill_q;
   logic                   rx_s;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d, dtick;
   logic [1:0]             samp_q, samp_d;
   logic [3:0]             bidx_q, bidx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
   logic                   stop_q, stop_d, armed_q, armed_d;
   logic                   at_d, maj, ferr_now, push_req;
   logic [EW-1:0]          push_ent;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                   brk_q, brk_d, brk_now, brk_pulse, break_q;
`endif

   // Synchroniser; fill_q flags when rx_s holds real line samples rather than reset ones,
   // so a line held low through reset cannot arm the receiver.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bit_in};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      end
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   // Receiver state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         samp_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         stop_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         samp_q  <= samp_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         stop_q  <= stop_d;
         armed_q <= armed_d;
      end
   end

   // Next state: bit timing, 3-sample vote at D-2..D, character assembly and push request
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      samp_d   = samp_q;
      bidx_d   = bidx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      stop_d   = stop_q;
      armed_d  = armed_q | (rx_s & fill_q[SYNC_STAGES-1]);
      push_req = 1'b0;
      dtick    = (state_q == S_START) ? D_START : D_BIT;
      at_d     = (cnt_q == dtick);
      maj      = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
      ferr_now = ferr_q | ~maj;
      push_ent = {ferr_now, perr_q, shift_q};
`ifdef UART_RX_BREAK_DETECT_EN
      brk_d     = brk_q;
      brk_now   = stop_q ? brk_q : (brk_q & ~maj);
      brk_pulse = 1'b0;
`endif
      if (state_q != S_IDLE) begin
         cnt_d = at_d ? '0 : cnt_q + CW'(1);
         if (cnt_q == dtick - CW'(2)) samp_d[0] = rx_s;
         if (cnt_q == dtick - CW'(1)) samp_d[1] = rx_s;
      end
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (armed_q && !rx_s) state_d = S_START;
         end
         S_START: if (at_d) begin
            if (!maj) begin
               state_d = S_DATA;
               bidx_d  = '0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               stop_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
               brk_d   = 1'b1;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: if (at_d) begin
            shift_d = {maj, shift_q[DATA_BITS-1:1]};
            par_d   = par_q ^ maj;
            bidx_d  = bidx_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d   = brk_q & ~maj;
`endif
            if (bidx_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: if (at_d) begin
            perr_d  = par_q ^ maj ^ ODD;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d   = brk_q & ~maj;
`endif
            state_d = S_STOP;
         end
         S_STOP: if (at_d) begin
            ferr_d = ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_d  = brk_now;
`endif
            if (stop_q == LAST_STOP) begin
               state_d = S_IDLE;
               if (ferr_now) armed_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
               brk_pulse = brk_now;
               push_req  = ~brk_now;
`else
               push_req  = 1'b1;
`endif
            end else begin
               stop_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef UART_RX_BREAK_DETECT_EN
   // Break tracking and one-cycle break indication
   always_ff @(posedge clk) begin
      if (rst) begin
         brk_q   <= 1'b0;
         break_q <= 1'b0;
      end else begin
         brk_q   <= brk_d;
         break_q <= brk_pulse;
      end
   end
   assign break_det = break_q;
`endif

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full, pop, do_push, ovf_q;
   logic [EW-1:0] head;

   assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
   assign pop     = (count_q != '0) && byte_out_ready;
   assign do_push = push_req && (!full || pop);

   // FIFO storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_ent;
   end

   // FIFO pointers, occupancy and drop indication
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (!do_push && pop) count_q <= count_q - (AW+1)'(1);
         ovf_q <= push_req && !do_push;
      end
   end

   assign head                = mem_q[rd_ptr_q];
   assign byte_out_valid      = (count_q != '0);
   assign byte_out_data       = byte_out_valid ? head[DATA_BITS-1:0] : '0;
   assign byte_out_parity_err = byte_out_valid & head[DATA_BITS];
   assign byte_out_frame_err  = byte_out_valid & head[DATA_BITS+1];
   assign fifo_count          = count_q;
   assign overflow            = ovf_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed and randomized bench for uart_rx_cfg (8E2, depth 4, 16 ticks per bit)
`timescale 1ns/1ps
module tb_uart_rx_cfg;
   localparam int TB = 16;

   logic       clk = 1'b0, rst = 1'b1, bit_in = 1'b1, byte_out_ready = 1'b0;
   logic [7:0] byte_out_data;
   logic       byte_out_parity_err, byte_out_frame_err, byte_out_valid, overflow;
   logic [2:0] fifo_count;
`ifdef UART_RX_BREAK_DETECT_EN
   logic       break_det;
`endif
   int   n_chk = 0, n_pass = 0, n_fail = 0, ovf_cnt = 0, brk_cnt = 0;
   logic valid_late;

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .CLK_FREQ_HZ(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
      .STOP_BITS(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in),
      .byte_out_data(byte_out_data), .byte_out_parity_err(byte_out_parity_err),
      .byte_out_frame_err(byte_out_frame_err), .byte_out_valid(byte_out_valid),
      .byte_out_ready(byte_out_ready), .fifo_count(fifo_count), .overflow(overflow)
`ifdef UART_RX_BREAK_DETECT_EN
      , .break_det(break_det)
`endif
   );

   always @(posedge clk) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
`ifdef UART_RX_BREAK_DETECT_EN
   always @(posedge clk) if (break_det === 1'b1) brk_cnt <= brk_cnt + 1;
`endif

   function automatic logic even_pbit(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      bit_in = v;
      repeat (n) @(negedge clk);
   endtask

   // Frame: start, 8 data LSB first, parity, stop0, stop1. gbit flips frame bit gbit for one
   // cycle at mid-bit. rdy_pulse raises ready for the single cycle holding the last stop decision.
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic s0, input logic s1,
                             input int gbit, input bit rdy_pulse);
      logic [10:0] bits;
      bits = {s0, pb, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (i == gbit) begin
            hold(bits[i], 8);
            hold(~bits[i], 1);
            hold(bits[i], 7);
         end else begin
            hold(bits[i], TB);
         end
      end
      hold(s1, 11);
      if (rdy_pulse) byte_out_ready = 1'b1;
      @(negedge clk);
      byte_out_ready = 1'b0;
      hold(s1, 3);
      valid_late = byte_out_valid;
      @(negedge clk);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
      chk({tag, ".valid"}, byte_out_valid, 1);
      chk({tag, ".data"}, byte_out_data, d);
      chk({tag, ".perr"}, byte_out_parity_err, pe);
      chk({tag, ".ferr"}, byte_out_frame_err, fe);
      byte_out_ready = 1'b1;
      @(negedge clk);
      byte_out_ready = 1'b0;
   endtask

   // Reference: even parity errors when data plus parity bit has odd weight; any low stop
   // is a framing error; with break detect, all-zero data/parity/first stop is swallowed.
   task automatic frame_and_check(input string tag, input logic [7:0] d, input logic pb,
                                  input logic s0, input logic s1, input int gbit);
      logic pe, fe, is_brk;
      int   b0, exp_n;
      pe = (^d) ^ pb;
      fe = !(s0 && s1);
`ifdef UART_RX_BREAK_DETECT_EN
      is_brk = (d == 8'h00) && !pb && !s0;
`else
      is_brk = 1'b0;
`endif
      exp_n = is_brk ? 0 : 1;
      b0 = brk_cnt;
      send_frame(d, pb, s0, s1, gbit, 1'b0);
      if (!s1) hold(1'b1, TB);
      hold(1'b1, 2);
      chk({tag, ".count"}, fifo_count, exp_n);
`ifdef UART_RX_BREAK_DETECT_EN
      chk({tag, ".break"}, brk_cnt - b0, is_brk);
`endif
      if (exp_n != 0) pop_check(tag, d, pe, fe);
      chk({tag, ".empty"}, fifo_count, 0);
   endtask

   initial begin
      int ovf0;
      logic [7:0] rd;
      logic rp, r0, r1;
      repeat (3) @(negedge clk);
      chk("rst.valid", byte_out_valid, 0);
      chk("rst.count", fifo_count, 0);
      chk("rst.ovf", overflow, 0);
      chk("rst.data", byte_out_data, 0);
      chk("rst.perr", byte_out_parity_err, 0);
      chk("rst.ferr", byte_out_frame_err, 0);
      rst = 1'b0;
      hold(1'b1, 10);

      send_frame(8'hA5, even_pbit(8'hA5), 1'b1, 1'b1, -1, 1'b0);
      chk("a5.valid_in_stop", valid_late, 1);
      hold(1'b1, 2);
      chk("a5.count", fifo_count, 1);
      pop_check("a5", 8'hA5, 1'b0, 1'b0);
      chk("a5.empty", fifo_count, 0);

      frame_and_check("par_bad", 8'h03, 1'b1, 1'b1, 1'b1, -1);
      frame_and_check("par_ok", 8'h03, 1'b0, 1'b1, 1'b1, -1);

      send_frame(8'h3C, even_pbit(8'h3C), 1'b1, 1'b0, -1, 1'b0);
      hold(1'b0, 20 * TB);
      chk("held_low.count", fifo_count, 1);
      pop_check("held_low", 8'h3C, 1'b0, 1'b1);
      chk("held_low.empty", fifo_count, 0);
      hold(1'b1, 2 * TB);
      frame_and_check("after_low", 8'h5A, even_pbit(8'h5A), 1'b1, 1'b1, -1);

      hold(1'b0, 4);
      hold(1'b1, 3 * TB);
      chk("glitch.count", fifo_count, 0);
      chk("glitch.valid", byte_out_valid, 0);
      frame_and_check("vote", 8'h5A, even_pbit(8'h5A), 1'b1, 1'b1, 4);

      ovf0 = ovf_cnt;
      for (int i = 1; i <= 5; i++) begin
         rd = 8'(i);
         send_frame(rd, even_pbit(rd), 1'b1, 1'b1, -1, 1'b0);
      end
      hold(1'b1, 2);
      chk("ovf.count", fifo_count, 4);
      chk("ovf.pulses", ovf_cnt - ovf0, 1);
      for (int i = 1; i <= 4; i++) pop_check("ovf.drain", 8'(i), 1'b0, 1'b0);
      chk("ovf.empty", fifo_count, 0);

      for (int i = 1; i <= 4; i++) begin
         rd = 8'(i);
         send_frame(rd, even_pbit(rd), 1'b1, 1'b1, -1, 1'b0);
      end
      ovf0 = ovf_cnt;
      send_frame(8'h05, even_pbit(8'h05), 1'b1, 1'b1, -1, 1'b1);
      hold(1'b1, 2);
      chk("fullpop.ovf", ovf_cnt - ovf0, 0);
      chk("fullpop.count", fifo_count, 4);
      for (int i = 2; i <= 5; i++) pop_check("fullpop.drain", 8'(i), 1'b0, 1'b0);

      hold(1'b0, TB);
      hold(1'b1, 3 * TB);
      rst = 1'b1;
      bit_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 15 * TB);
      chk("rstlow.count", fifo_count, 0);
      chk("rstlow.valid", byte_out_valid, 0);
      hold(1'b1, 3 * TB);
      chk("rstlow.high", fifo_count, 0);
      frame_and_check("post_rst", 8'hC3, even_pbit(8'hC3), 1'b1, 1'b1, -1);

      frame_and_check("break", 8'h00, 1'b0, 1'b0, 1'b0, -1);

      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         rp = even_pbit(rd) ^ ($urandom_range(0, 3) == 0);
         r0 = ($urandom_range(0, 7) != 0);
         r1 = ($urandom_range(0, 7) != 0);
         frame_and_check("rnd", rd, rp, r0, r1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1);
         hold(1'b1, $urandom_range(0, 20));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
